counting_sched: RTL and testbench
=================================

# counting_sched

Round-robin scheduler that time-shares one 2-bit-symbol pattern detector (pattern 1,2,3 with run-on 3s) among `N_REQ` independent symbol streams. It keeps a saved detector context and a saturating match counter per stream and accepts at most one symbol per cycle. It sits between the symbol producers and the result consumer, and reports every decision on a registered result port.

## Interface
- `N_REQ`, 4: number of requesters; 2..8. `ID_W` = ceil(log2(N_REQ)) is derived.
- `CNT_W`, 8: width of each per-requester match counter.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: global enable; when 0 no symbol is accepted.
- `req_valid` in N_REQ: requester i offers a symbol.
- `req_num` in 2*N_REQ: symbol of requester i in bits [2i+1:2i].
- `req_ready` out N_REQ: grant, combinational, at most one bit set.
- `clr` in N_REQ: synchronous clear of requester i's context and counter.
- `out_valid` out 1: registered; one accepted symbol was processed last edge.
- `out_id` out ID_W: requester of that symbol.
- `out_state` out 2: that requester's new detector state.
- `out_match` out 1: new state is S3.
- `rd_sel` in ID_W: counter read select.
- `rd_cnt` out CNT_W: combinational read of counter `rd_sel`.

## Operation
- Detector states: S0=00, S1=01, S2=10, S3=11. Transitions on symbol n:
  - S0: n==1 goes to S1; otherwise S0.
  - S1: n==2 goes to S2; n==1 goes to S1; otherwise S0.
  - S2: n==3 goes to S3; n==1 goes to S1; otherwise S2.
  - S3: n==3 goes to S3; n==1 goes to S1; otherwise S0.
- Each requester has a private 2-bit context `ctx[i]`. Only the accepted requester's context advances.
- Eligible set: `req_valid[i] & ~clr[i] & en`.
- Grant: the first eligible index searching ptr, ptr+1, … modulo N_REQ. `req_ready[i]`=1 only for that index; all zero if none is eligible.
- Transfer when `req_valid[i] & req_ready[i]`. On that edge:
  - `ctx[i]` gets the next state.
  - `ptr` gets (i+1) mod N_REQ.
  - `cnt[i]` increments if the next state is S3, saturating at 2^CNT_W−1.
  - The result port loads i, the next state and the match flag; `out_valid` goes to 1.
- No transfer: `out_valid` goes to 0. `out_id`, `out_state` and `out_match` hold their last values. `ptr` holds.
- `clr[i]`=1: at the edge, `ctx[i]` becomes S0 and `cnt[i]` becomes 0. Requester i is never granted in that cycle, so clear and accept never collide. Other requesters are unaffected.
- `en`=0: no grants; contexts, counters and `ptr` hold. `clr` still acts.
- Undefined `rd_sel` (≥ N_REQ): `rd_cnt` = 0.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge):
  - all `ctx` = S0, all `cnt` = 0, `ptr` = 0;
  - `out_valid` = 0, `out_id` = 0, `out_state` = S0, `out_match` = 0.
- `req_ready` follows same-cycle inputs combinationally. A requester may drop `req_valid` without a transfer.
- Latency: symbol accepted at edge k produces the result during cycle k+1. `rd_cnt` reflects the increment from cycle k+1.
- Throughput: 1 symbol per cycle aggregate. With all N_REQ requesters valid continuously, each is granted exactly once every N_REQ cycles.
- Back-to-back accepts from the same requester are allowed when it is the only eligible one. The context update is visible to the next accept with no bubble.
- Reset asserted mid-stream discards all contexts and counts immediately. Outputs reach their reset values without waiting for a clock.

## Test plan
- Reset, then only requester 0 valid with symbols 1,2,3,3,0 on consecutive cycles -> `out_state` S1,S2,S3,S3,S0; `out_match` 0,0,1,1,0; `rd_cnt`(sel 0)=2.
- All 4 requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Interleaved streams 1,2,3 on requesters 1 and 3 each give one match, with contexts kept independent.
- Requester 2 at S2 receives symbol 0 -> stays S2. Then symbol 1 -> S1. Then 2,3 -> S3 with `out_match`=1.
- `clr[1]`=1 while `req_valid[1]`=1 and ptr=1 -> `req_ready[1]`=0 and requester 2 is granted. Next cycle `ctx[1]`=S0 and `cnt[1]`=0.
- Set CNT_W=2 and produce 5 matches on requester 0 -> `rd_cnt` sequence 1,2,3,3,3.
- `en`=0 for 3 cycles with all requesters valid -> `req_ready`=0 and `out_valid`=0; ptr unchanged on re-enable. Assert `rst_n`=0 mid-cycle -> outputs 0 immediately, all counters 0.

Source files
------------

// File: rtl/counting_sched_if.sv
// Bundle between symbol producers / result consumer and counting_sched.
//   master: producer side (drives en, req_valid, req_num, clr, rd_sel)
//   slave : scheduler side (drives req_ready, out_*, rd_cnt)
interface counting_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic                 en;
    logic [N_REQ-1:0]     req_valid;
    logic [2*N_REQ-1:0]   req_num;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     clr;
    logic                 out_valid;
    logic [ID_W-1:0]      out_id;
    logic [1:0]           out_state;
    logic                 out_match;
    logic [ID_W-1:0]      rd_sel;
    logic [CNT_W-1:0]     rd_cnt;

    modport master (
        output en, req_valid, req_num, clr, rd_sel,
        input  req_ready, out_valid, out_id, out_state, out_match, rd_cnt
    );

    modport slave (
        input  en, req_valid, req_num, clr, rd_sel,
        output req_ready, out_valid, out_id, out_state, out_match, rd_cnt
    );
endinterface

// File: rtl/counting_sched.sv
// Round-robin scheduler time-sharing one 1,2,3 pattern detector across
// N_REQ symbol streams, with a saved detector context and a saturating
// match counter per stream.
//   clk, rst_n : clock, async active-low reset
//   bus.en, req_valid, req_num, clr : per-requester offers and clears
//   bus.req_ready                   : combinational one-hot grant
//   bus.out_valid/id/state/match    : registered result of last accept
//   bus.rd_sel / rd_cnt             : combinational counter read port
module counting_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    counting_sched_if.slave bus
);
    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_e;

    // Pattern detector transition for one symbol
    function automatic det_state_e det_next(input det_state_e s, input logic [1:0] n);
        det_state_e nx;
        nx = S0;
        case (s)
            S0:      nx = (n == 2'd1) ? S1 : S0;
            S1:      nx = (n == 2'd2) ? S2 : ((n == 2'd1) ? S1 : S0);
            S2:      nx = (n == 2'd3) ? S3 : ((n == 2'd1) ? S1 : S2);
            default: nx = (n == 2'd3) ? S3 : ((n == 2'd1) ? S1 : S0);
        endcase
        return nx;
    endfunction

    det_state_e       ctx_q [N_REQ];
    det_state_e       ctx_d [N_REQ];
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             out_valid_q, out_valid_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    det_state_e       out_state_q, out_state_d;
    logic             out_match_q, out_match_d;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic             gnt_any;
    logic [ID_W-1:0]  gnt_id;
    logic [1:0]       gnt_num;
    det_state_e       gnt_next;
    int unsigned      idx;

    // Rotating priority search starting at ptr; cleared requesters are skipped
    always_comb begin
        elig    = bus.req_valid & ~bus.clr & {N_REQ{bus.en}};
        grant   = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!gnt_any && elig[ID_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
        if (gnt_any) begin
            grant[gnt_id] = 1'b1;
        end
        gnt_num  = bus.req_num[{gnt_id, 1'b0} +: 2];
        gnt_next = det_next(ctx_q[gnt_id], gnt_num);
    end

    // Next-state for contexts, counters, pointer and result port
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ctx_d[i] = ctx_q[i];
            cnt_d[i] = cnt_q[i];
        end
        ptr_d       = ptr_q;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_state_d = out_state_q;
        out_match_d = out_match_q;

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.clr[i]) begin
                ctx_d[i] = S0;
                cnt_d[i] = '0;
            end
        end

        // A granted requester is never being cleared, so no overlap with the loop above
        if (gnt_any) begin
            ctx_d[gnt_id] = gnt_next;
            if (gnt_next == S3 && cnt_q[gnt_id] != CNT_MAX) begin
                cnt_d[gnt_id] = cnt_q[gnt_id] + CNT_W'(1);
            end
            ptr_d       = (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
            out_valid_d = 1'b1;
            out_id_d    = gnt_id;
            out_state_d = gnt_next;
            out_match_d = (gnt_next == S3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                ctx_q[i] <= S0;
                cnt_q[i] <= '0;
            end
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_state_q <= S0;
            out_match_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                ctx_q[i] <= ctx_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_state_q <= out_state_d;
            out_match_q <= out_match_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_state = out_state_q;
    assign bus.out_match = out_match_q;
    assign bus.rd_cnt    = (32'(bus.rd_sel) < N_REQ) ? cnt_q[bus.rd_sel] : '0;

endmodule

// File: tb/tb_counting_sched.sv
// Directed bench for counting_sched: a default instance (N_REQ=4, CNT_W=8)
// and a narrow-counter instance (CNT_W=2) for saturation.
module tb_counting_sched;
    logic clk;
    logic rst_n;

    counting_sched_if #(.N_REQ(4), .CNT_W(8)) bus ();
    counting_sched_if #(.N_REQ(4), .CNT_W(2)) bus2 ();

    counting_sched #(.N_REQ(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    counting_sched #(.N_REQ(4), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_num(input int r, input logic [1:0] v);
        bus.req_num[2*r +: 2] = v;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] id, input logic [31:0] st);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_id"},    32'(bus.out_id),    id);
        chk({tag, "_state"}, 32'(bus.out_state), st);
        chk({tag, "_match"}, 32'(bus.out_match), 32'(st == 32'd3));
    endtask

    logic [1:0] t1_sym [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [1:0] t1_st  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [1:0] seq_sym [3] = '{2'd1, 2'd2, 2'd3};
    logic [1:0] seq_st  [3] = '{2'd1, 2'd2, 2'd3};
    logic [1:0] t3_sym [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] t3_st  [6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3};
    logic [1:0] t5_sym [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [1:0] t5_cnt [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int gcnt [4];

    initial begin
        bus.en = 1'b1;  bus.req_valid = '0;  bus.req_num = '0;  bus.clr = '0;  bus.rd_sel = '0;
        bus2.en = 1'b1; bus2.req_valid = '0; bus2.req_num = '0; bus2.clr = '0; bus2.rd_sel = '0;
        rst_n = 1'b0;
        repeat (2) step();

        // Reset values
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_id",    32'(bus.out_id),    32'd0);
        chk("rst_state", 32'(bus.out_state), 32'd0);
        chk("rst_match", 32'(bus.out_match), 32'd0);
        chk("rst_cnt",   32'(bus.rd_cnt),    32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_valid", 32'(bus.out_valid), 32'd0);

        // Single stream on requester 0: 1,2,3,3,0
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            set_num(0, t1_sym[i]);
            #1;
            chk("t1_ready", 32'(bus.req_ready), 32'h1);
            step();
            chk_out("t1", 32'd0, 32'(t1_st[i]));
        end
        bus.req_valid = '0;
        bus.rd_sel = 2'd0;
        #1;
        chk("t1_cnt0", 32'(bus.rd_cnt), 32'd2);
        step();
        chk("t1_drop_valid", 32'(bus.out_valid), 32'd0);

        // All four valid, ptr starts at 1; streams 1,2,3 interleaved on requesters 1 and 3
        for (int r = 0; r < 4; r++) gcnt[r] = 0;
        bus.req_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            int g;
            g = (1 + c) % 4;
            for (int r = 0; r < 4; r++) begin
                if ((r == 1 || r == 3) && gcnt[r] < 3) set_num(r, seq_sym[gcnt[r]]);
                else set_num(r, 2'd0);
            end
            #1;
            chk("t2_ready", 32'(bus.req_ready), 32'(1 << g));
            step();
            chk_out("t2", 32'(g), (g % 2 == 1) ? 32'(seq_st[gcnt[g]]) : 32'd0);
            gcnt[g]++;
        end
        bus.req_valid = '0;
        bus.req_num = '0;
        bus.rd_sel = 2'd1; #1; chk("t2_cnt1", 32'(bus.rd_cnt), 32'd1);
        bus.rd_sel = 2'd3; #1; chk("t2_cnt3", 32'(bus.rd_cnt), 32'd1);
        bus.rd_sel = 2'd0; #1; chk("t2_cnt0", 32'(bus.rd_cnt), 32'd2);

        // Requester 2 alone: S2 holds on 0, re-arms on 1, then matches
        bus.req_valid = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            set_num(2, t3_sym[i]);
            #1;
            chk("t3_ready", 32'(bus.req_ready), 32'h4);
            step();
            chk_out("t3", 32'd2, 32'(t3_st[i]));
        end
        bus.req_valid = '0;
        bus.rd_sel = 2'd2; #1; chk("t3_cnt2", 32'(bus.rd_cnt), 32'd1);
        step();
        chk("t3_hold_valid", 32'(bus.out_valid), 32'd0);
        chk("t3_hold_id",    32'(bus.out_id),    32'd2);
        chk("t3_hold_state", 32'(bus.out_state), 32'd3);
        chk("t3_hold_match", 32'(bus.out_match), 32'd1);

        // Put ctx[1] at S1, then bring ptr to 1
        bus.req_valid = 4'b0010; set_num(1, 2'd1); #1;
        step();
        chk_out("t4_pre1", 32'd1, 32'd1);
        bus.req_valid = 4'b0001; set_num(0, 2'd0); #1;
        step();
        chk_out("t4_pre0", 32'd0, 32'd0);
        // Clear requester 1 while it is valid at ptr=1: requester 2 wins
        bus.req_valid = 4'b0110; bus.clr = 4'b0010;
        set_num(1, 2'd2); set_num(2, 2'd3);
        #1;
        chk("t4_ready", 32'(bus.req_ready), 32'h4);
        step();
        chk_out("t4_clr", 32'd2, 32'd3);
        bus.clr = '0;
        bus.req_valid = '0;
        bus.rd_sel = 2'd1; #1; chk("t4_cnt1", 32'(bus.rd_cnt), 32'd0);
        bus.rd_sel = 2'd2; #1; chk("t4_cnt2", 32'(bus.rd_cnt), 32'd2);
        // Cleared context: symbol 2 from S0 stays S0 (S1 would have gone to S2)
        bus.req_valid = 4'b0010;
        #1;
        chk("t4_ready1", 32'(bus.req_ready), 32'h2);
        step();
        chk_out("t4_after", 32'd1, 32'd0);
        bus.req_valid = '0;
        bus.req_num = '0;

        // Saturating counter on the CNT_W=2 instance
        bus2.req_valid = 4'b0001;
        bus2.rd_sel = 2'd0;
        for (int i = 0; i < 7; i++) begin
            bus2.req_num = {6'd0, t5_sym[i]};
            step();
            chk("t5_match", 32'(bus2.out_match), 32'(t5_sym[i] == 2'd3));
            chk("t5_cnt",   32'(bus2.rd_cnt),    32'(t5_cnt[i]));
        end
        bus2.req_valid = '0;

        // Disabled: no grants; clr still acts
        bus.req_valid = 4'hF;
        bus.en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.clr = (c == 1) ? 4'b1000 : 4'b0000;
            #1;
            chk("t6_ready", 32'(bus.req_ready), 32'd0);
            step();
            chk("t6_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.clr = '0;
        bus.rd_sel = 2'd3; #1; chk("t6_cnt3", 32'(bus.rd_cnt), 32'd0);
        bus.rd_sel = 2'd2; #1; chk("t6_cnt2", 32'(bus.rd_cnt), 32'd2);
        bus.en = 1'b1;
        set_num(2, 2'd1);
        #1;
        chk("t6_reen_ready", 32'(bus.req_ready), 32'h4);
        step();
        chk_out("t6_reen", 32'd2, 32'd1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_id",    32'(bus.out_id),    32'd0);
        chk("arst_state", 32'(bus.out_state), 32'd0);
        chk("arst_match", 32'(bus.out_match), 32'd0);
        for (int r = 0; r < 4; r++) begin
            bus.rd_sel = 2'(r);
            #1;
            chk("arst_cnt", 32'(bus.rd_cnt), 32'd0);
        end
        bus.req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
